// File: rtl/apb_controller.sv
// APB-side engine of the AHB-to-APB bridge: runs each accepted AHB transfer as an APB SETUP/ACCESS pair.
// Optional ACCESS-phase timeout is built when APB_TIMEOUT_EN is defined.
module apb_controller #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        Hclk,
   input  logic        Hresetn,
   input  logic        valid,
   input  logic [31:0] Haddr,
   input  logic        Hwrite,
   input  logic [2:0]  temp_selx,
   input  logic [31:0] Hwdata,
   input  logic        Pready,
   output logic [2:0]  Pselx,
   output logic        Penable,
   output logic        Pwrite,
   output logic [31:0] Paddr,
   output logic [31:0] Pwdata,
   output logic        Hreadyout,
   output logic        timeout_err,
   output logic [1:0]  o_dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WWAIT  = 2'd1,
      SETUP  = 2'd2,
      ACCESS = 2'd3
   } state_t;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("apb_controller: TIMEOUT_CYCLES must be in 1..255");
   end

   state_t      r_state;
   logic [2:0]  r_sel;
   logic [2:0]  r_pselx;
   logic        r_penable;
   logic        r_pwrite;
   logic [31:0] r_paddr;
   logic [31:0] r_pwdata;
   logic        w_timeout;
   logic        w_complete;
   logic        w_accept;

`ifdef APB_TIMEOUT_EN
   logic [7:0] r_wait_cnt;

   // Counts ACCESS cycles spent with Pready low; the last allowed one force-completes.
   assign w_timeout = (r_state == ACCESS) && !Pready &&
                      (r_wait_cnt == 8'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         r_wait_cnt <= 8'd0;
      end else if (r_state == SETUP) begin
         r_wait_cnt <= 8'd0;
      end else if (r_state == ACCESS && !Pready) begin
         r_wait_cnt <= r_wait_cnt + 8'd1;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   assign w_complete = (r_state == ACCESS) && (Pready || w_timeout);
   assign w_accept   = (r_state == IDLE) || w_complete;

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         r_state   <= IDLE;
         r_sel     <= 3'b000;
         r_pselx   <= 3'b000;
         r_penable <= 1'b0;
         r_pwrite  <= 1'b0;
         r_paddr   <= 32'd0;
         r_pwdata  <= 32'd0;
      end else begin
         unique case (r_state)
            IDLE, ACCESS: begin
               // An ACCESS cycle without completion falls through with everything held.
               if (w_accept) begin
                  if (valid) begin
                     r_paddr   <= Haddr;
                     r_pwrite  <= Hwrite;
                     r_sel     <= temp_selx;
                     r_pselx   <= Hwrite ? 3'b000 : temp_selx;
                     r_penable <= 1'b0;
                     r_state   <= Hwrite ? WWAIT : SETUP;
                  end else begin
                     r_pselx   <= 3'b000;
                     r_penable <= 1'b0;
                     r_state   <= IDLE;
                  end
               end
            end
            WWAIT: begin
               r_pwdata <= Hwdata;
               r_pselx  <= r_sel;
               r_state  <= SETUP;
            end
            SETUP: begin
               r_penable <= 1'b1;
               r_state   <= ACCESS;
            end
         endcase
      end
   end

   assign Pselx       = r_pselx;
   assign Penable     = r_penable;
   assign Pwrite      = r_pwrite;
   assign Paddr       = r_paddr;
   assign Pwdata      = r_pwdata;
   assign Hreadyout   = w_accept;
   assign timeout_err = w_timeout;
   assign o_dbg_state = r_state;

endmodule

// File: doc/apb_controller.md
# apb_controller

APB-side engine of the AHB-to-APB bridge. It accepts qualified AHB transfers from the AHB slave interface (`valid`, `temp_selx`, address-phase `Haddr`/`Hwrite`, data-phase `Hwdata`). It runs each transfer as an APB SETUP/ACCESS sequence on the selected peripheral and holds the AHB data phase with `Hreadyout` until the APB transfer completes. Read data returns to AHB through the slave's `Hrdata = Prdata` path, aligned with the `Hreadyout` high cycle.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 16: ACCESS-phase wait limit. Used only when `APB_TIMEOUT_EN` is defined. Legal range 1..255.

Ports:
- `Hclk`  in  1  clock; all state changes on the rising edge.
- `Hresetn`  in  1  asynchronous, active-low reset.
- `valid`  in  1  qualified AHB NONSEQ/SEQ address phase (from AHB slave).
- `Haddr`  in  32  AHB address, sampled in the address-phase cycle.
- `Hwrite`  in  1  AHB direction, sampled in the address-phase cycle.
- `temp_selx`  in  3  one-hot peripheral select, sampled in the address-phase cycle.
- `Hwdata`  in  32  AHB write data, valid in the first data-phase cycle.
- `Pready`  in  1  APB completer ready.
- `Pselx`  out  3  APB select, one-hot or zero.
- `Penable`  out  1  APB enable.
- `Pwrite`  out  1  APB direction.
- `Paddr`  out  32  APB address.
- `Pwdata`  out  32  APB write data.
- `Hreadyout`  out  1  AHB ready back to master/decoder.
- `timeout_err`  out  1  one-cycle pulse when a transfer is force-completed by timeout.

## Operation
- States: IDLE, WWAIT, SETUP, ACCESS. The state is 2-bit registered.
- Accept point is IDLE, or ACCESS with completion. At an accept point, `valid`=1 latches `Haddr`→`Paddr`, `Hwrite`→`Pwrite` and `temp_selx`→sel register. Next state is WWAIT for a write and SETUP for a read.
- `valid` is ignored in WWAIT, SETUP, and ACCESS without completion. The master holds the address because `Hreadyout`=0.
- IDLE with `valid`=0: stay in IDLE.
- WWAIT: latch `Hwdata`→`Pwdata`, then go to SETUP.
- SETUP: `Pselx`=sel, `Penable`=0, then go to ACCESS unconditionally.
- ACCESS: `Pselx`=sel, `Penable`=1. Completion is `Pready`=1, or a timeout when enabled.
  - On completion with `valid`=1: accept the next transfer.
  - On completion with `valid`=0: go to IDLE.
  - Without completion: stay in ACCESS with all APB outputs stable.
- `Pselx`=0 and `Penable`=0 in IDLE and WWAIT.
- `Paddr`, `Pwrite` and `Pwdata` hold their last values while idle. `Pwdata` is not updated for reads.
- `Hreadyout` is combinational: 1 in IDLE, and 1 in ACCESS when completion occurs; 0 otherwise.
- `temp_selx`=000 with `valid`=1 cannot occur, because the slave gates `valid` by the same address range. The block still runs the sequence, with `Pselx`=000.

## Timing
- Reset, asynchronous and effective immediately, including mid-transfer:
  - state is IDLE;
  - `Pselx`=0, `Penable`=0, `Pwrite`=0, `Paddr`=0, `Pwdata`=0, `timeout_err`=0, wait counter 0;
  - `Hreadyout`=1.
  - An aborted APB transfer is not resumed.
- Read, address phase in cycle N with zero-wait `Pready`:
  - N+1 is SETUP, with `Hreadyout`=0;
  - N+2 is ACCESS, with `Hreadyout`=1 and `Prdata` valid to AHB.
  - One AHB wait state.
- Write, address phase in cycle N:
  - N+1 is WWAIT;
  - N+2 is SETUP;
  - N+3 is ACCESS, with `Hreadyout`=1.
  - Two AHB wait states.
- Each APB `Pready`=0 cycle in ACCESS adds one wait state.
- Back-to-back transfers: the next address phase overlaps the completing ACCESS cycle. There is no IDLE cycle between transfers.

## Configuration
- `APB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with `Pready`=0.
  - When the counter equals `TIMEOUT_CYCLES-1` and `Pready`=0, the cycle is treated as completion: `Hreadyout`=1, and `timeout_err`=1 for that cycle only, driven combinationally.
- `APB_TIMEOUT_EN` not defined:
  - No counter is built.
  - `timeout_err` is tied to 0.
  - ACCESS waits indefinitely for `Pready`.

## Test plan
- Read: `valid`=1, `Hwrite`=0, `Haddr`=32'h8000_0010, `temp_selx`=001, `Pready`=1 → N+1 `Pselx`=001/`Penable`=0, N+2 `Penable`=1, `Hreadyout`=1, then IDLE.
- Write: `Haddr`=32'h8400_0004, `Hwdata`=32'hA5A5_1234 in N+1, `Pready`=1 → `Pwdata`=32'hA5A5_1234, `Pselx`=010, `Pwrite`=1 in N+2..N+3, `Hreadyout` low N+1..N+2.
- Wait states: read with `Pready`=0 for 3 ACCESS cycles → ACCESS lasts 4 cycles with outputs stable, and `Hreadyout`=1 only in the 4th.
- Back-to-back: write to 32'h8800_0000 then read to 32'h8000_0020, with the second `valid` in the completing ACCESS cycle → SETUP of the read follows immediately, with `Pselx` 100→001 and no IDLE cycle.
- Reset mid-ACCESS: deassert `Hresetn` during ACCESS → `Pselx`=0, `Penable`=0, `Hreadyout`=1 without waiting for a clock edge, and state is IDLE after release.
- Timeout (`APB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4): `Pready` held at 0 → a single `timeout_err` pulse with `Hreadyout`=1 in the 4th ACCESS cycle, then IDLE.
